// File: rtl/ibex_pkg.sv
// Shared ibex types used by the PMP check arbiter: privilege levels, PMP access
// types, arbiter FSM states and the registered request bundle.
package ibex_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_M = 2'b11,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_U = 2'b00
  } priv_lvl_e;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CHECK,
    ARB_RESP
  } pmp_arb_state_e;

  localparam int unsigned PMP_ADDR_W = 34;

  typedef struct packed {
    logic [PMP_ADDR_W-1:0] addr;
    pmp_req_e              acc_type;
    priv_lvl_e             priv;
  } pmp_chk_req_t;

endpackage

// File: rtl/ibex_pmp_rr_arb.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// searching cyclically upward.
module ibex_pmp_rr_arb #(
  parameter  int unsigned NumReq = 3,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   idx,
  output logic              any
);

  logic [IdxW:0] cand;

  assign any = |valid;

  // Walk offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumReq)) cand = cand - (IdxW+1)'(NumReq);
      if (valid[cand[IdxW-1:0]]) idx = cand[IdxW-1:0];
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/ibex_pmp_chk_arb.sv
// Shares one PMP access-check channel between NumReq requesters. One request in
// flight; a PMP CSR write during the check forces a re-sample of the verdict.
module ibex_pmp_chk_arb
  import ibex_pkg::*;
#(
  parameter  int unsigned NumReq = 3,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic      [NumReq-1:0]               req_valid_i,
  output logic      [NumReq-1:0]               req_ready_o,
  input  logic      [NumReq-1:0][PMP_ADDR_W-1:0] req_addr_i,
  input  pmp_req_e  [NumReq-1:0]               req_type_i,
  input  priv_lvl_e [NumReq-1:0]               req_priv_i,
  output logic      [NumReq-1:0]               rsp_valid_o,
  output logic                                 rsp_err_o,
  input  logic      [NumReq-1:0]               rsp_ready_i,
  input  logic                                 csr_pmp_wr_i,
  output logic      [PMP_ADDR_W-1:0]           pmp_req_addr_o,
  output pmp_req_e                             pmp_req_type_o,
  output priv_lvl_e                            pmp_priv_o,
  input  logic                                 pmp_req_err_i,
  output logic                                 busy_o
);

  pmp_arb_state_e state_q, state_d;
  pmp_chk_req_t   req_q;
  logic [IdxW-1:0] idx_q, rr_ptr_q, gnt_idx;
  logic [NumReq-1:0] gnt;
  logic gnt_any, load, sample, hs, err_q;

  ibex_pmp_rr_arb #(.NumReq(NumReq)) u_rr_arb (
    .valid (req_valid_i),
    .ptr   (rr_ptr_q),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    load        = 1'b0;
    sample      = 1'b0;
    hs          = 1'b0;
    unique case (state_q)
      ARB_IDLE: if (gnt_any) begin
        req_ready_o = gnt;
        load        = 1'b1;
        state_d     = ARB_CHECK;
      end
      // A CSR write this cycle makes the channel's verdict stale: hold and retry.
      ARB_CHECK: if (!csr_pmp_wr_i) begin
        sample  = 1'b1;
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        rsp_valid_o[idx_q] = 1'b1;
        if (rsp_ready_i[idx_q]) begin
          hs      = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      req_q    <= '{addr: '0, acc_type: PMP_ACC_READ, priv: PRIV_LVL_M};
      idx_q    <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        req_q <= '{addr: req_addr_i[gnt_idx], acc_type: req_type_i[gnt_idx],
                   priv: req_priv_i[gnt_idx]};
        idx_q <= gnt_idx;
      end
      if (sample) err_q <= pmp_req_err_i;
      if (hs) rr_ptr_q <= (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  assign pmp_req_addr_o = req_q.addr;
  assign pmp_req_type_o = req_q.acc_type;
  assign pmp_priv_o     = req_q.priv;
  assign rsp_err_o      = (state_q == ARB_RESP) & err_q;
  assign busy_o         = (state_q != ARB_IDLE);

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_o));
  a_rsp_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(rsp_valid_o));
  a_ready_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q != ARB_IDLE) |-> (req_ready_o == '0));
  a_rsp_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (|(rsp_valid_o & ~rsp_ready_i)) |=> (rsp_valid_o == $past(rsp_valid_o)));

endmodule
